// File: rtl/y_mux_pipe.sv
// y_mux_pipe: NCH-channel, WIDTH-bit multiplexer with a registered output
// stage and valid/ready handshakes on every input channel and on the output.
//
// Selection modes:
//   mode = 0 : fixed select; channel `sel` when it is in range and valid
//   mode = 1 : round-robin; first valid channel scanning from ptr with wrap
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   in_data[NCH*WIDTH]  channel k at [k*WIDTH +: WIDTH]
//   in_valid[NCH]       per-channel valid
//   in_ready[NCH]       per-channel accept (combinational, one-hot or zero)
//   mode, sel           selection mode / fixed-select index
//   out_data, out_sel   registered word and the channel that produced it
//   out_valid, out_ready output handshake
//
// Optional build macro YMUX_PIPE_STATS_EN adds:
//   xfer_count[16]      saturating count of output handshakes
//   drop_sel            one-cycle flag after a mode-0 cycle with sel >= NCH

module y_mux_pipe_lane #(
  parameter int SELW = 2,
  parameter int K    = 0
) (
  input  logic            go,
  input  logic [SELW-1:0] idx,
  output logic            rdy
);
  assign rdy = go & (idx == SELW'(K));
endmodule

module y_mux_pipe #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef YMUX_PIPE_STATS_EN
  ,
  output logic [15:0]          xfer_count,
  output logic                 drop_sel
`endif
);

  localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

  logic [NCH-1:0][WIDTH-1:0] ch;
  logic [SELW-1:0]           ptr;
  logic                      load_en, xfer;
  logic                      sel_ok, fx_vld, rr_vld, ch_vld;
  logic [SELW-1:0]           rr_idx, ch_idx;

  assign ch      = in_data;
  assign load_en = ~out_valid | out_ready;

  // Fixed select: out-of-range sel never picks anything.
  assign sel_ok  = ({1'b0, sel} < NCH_W);
  assign fx_vld  = sel_ok ? in_valid[sel] : 1'b0;

  // Round-robin: walk offsets from the top down so the lowest offset from
  // ptr (the first valid channel in scan order) is the last one written.
  always_comb begin
    logic [SELW:0] sum;
    rr_vld = 1'b0;
    rr_idx = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (SELW+1)'(i);
      if (sum >= NCH_W) sum = sum - NCH_W;
      if (in_valid[sum[SELW-1:0]]) begin
        rr_vld = 1'b1;
        rr_idx = sum[SELW-1:0];
      end
    end
  end

  assign ch_vld = mode ? rr_vld : fx_vld;
  assign ch_idx = mode ? rr_idx : sel;
  assign xfer   = load_en & ch_vld & rst_n;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    y_mux_pipe_lane #(.SELW(SELW), .K(k)) u_lane (
      .go  (xfer),
      .idx (ch_idx),
      .rdy (in_ready[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= ch[ch_idx];
      out_sel   <= ch_idx;
      if (mode) ptr <= ({1'b0, ch_idx} == NCH_W - 1'b1) ? '0 : ch_idx + 1'b1;
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef YMUX_PIPE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_count <= '0;
      drop_sel   <= 1'b0;
    end else begin
      if (out_valid & out_ready & (xfer_count != 16'hFFFF))
        xfer_count <= xfer_count + 16'd1;
      drop_sel <= ~mode & ~sel_ok;
    end
  end
`endif

endmodule

// File: tb/tb_y_mux_pipe.sv
module tb_y_mux_pipe;
  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready;
  logic           mode;
  logic [1:0]     sel, out_sel;
  logic [W-1:0]   out_data;
  logic           out_valid, out_ready;
  int             total = 0;
  int             bad   = 0;

`ifdef YMUX_PIPE_STATS_EN
  logic [15:0] xfer_count;
  logic        drop_sel;
`endif

  always #5 clk = ~clk;

  y_mux_pipe #(.WIDTH(W), .NCH(N), .SELW(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
`ifdef YMUX_PIPE_STATS_EN
    , .xfer_count(xfer_count), .drop_sel(drop_sel)
`endif
  );

`ifdef YMUX_PIPE_STATS_EN
  logic [3*W-1:0] s_data;
  logic [2:0]     s_valid, s_ready;
  logic           s_mode, s_oval, s_ordy, s_drop;
  logic [1:0]     s_sel, s_osel;
  logic [W-1:0]   s_odata;
  logic [15:0]    s_cnt;

  y_mux_pipe #(.WIDTH(W), .NCH(3), .SELW(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(s_data), .in_valid(s_valid),
    .in_ready(s_ready), .mode(s_mode), .sel(s_sel), .out_data(s_odata),
    .out_sel(s_osel), .out_valid(s_oval), .out_ready(s_ordy),
    .xfer_count(s_cnt), .drop_sel(s_drop)
  );
`endif

  function automatic logic [W-1:0] chv(input int k);
    return 32'hC0DE_0000 + W'(k);
  endfunction

  task automatic set_default_data();
    for (int k = 0; k < N; k++) in_data[k*W +: W] = chv(k);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b1; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1;
    set_default_data();
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL reset_out_sel got=%0d exp=0", out_sel); end
  endtask

  task automatic test_fixed();
    @(negedge clk);
    rst_n = 1'b1; mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    in_data[2*W +: W] = 32'hDEADBEEF;
    #1;
    total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL fixed_in_ready got=%b exp=0100", in_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fixed_out_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 32'hDEADBEEF) begin bad++; $display("FAIL fixed_out_data got=%h exp=deadbeef", out_data); end
    total++; if (out_sel !== 2'd2) begin bad++; $display("FAIL fixed_out_sel got=%0d exp=2", out_sel); end
    // sel points at an idle channel: nothing accepted, held word drains
    @(negedge clk);
    sel = 2'd3;
    #1;
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL fixed_idle_in_ready got=%b exp=0000", in_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 32'hDEADBEEF) begin bad++; $display("FAIL drain_out_data got=%h exp=deadbeef", out_data); end
    total++; if (out_sel !== 2'd2) begin bad++; $display("FAIL drain_out_sel got=%0d exp=2", out_sel); end
    set_default_data();
  endtask

  task automatic test_back_to_back();
    int exp;
    @(negedge clk);
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      exp = c % N;
      #1;
      total++; if (in_ready !== 4'(1 << exp)) begin bad++; $display("FAIL rr_in_ready[%0d] got=%b exp=%0d", c, in_ready, exp); end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || out_sel !== 2'(exp) || out_data !== chv(exp))
        begin bad++; $display("FAIL rr_out[%0d] got=v%b s%0d d%h exp=v1 s%0d d%h", c, out_valid, out_sel, out_data, exp, chv(exp)); end
      @(negedge clk);
    end
  endtask

  task automatic test_rr_wrap();
    int seq [3] = '{3, 1, 3};
    // ptr is 1 here; one transfer from channel 1 moves it to 2
    in_valid = 4'b0010;
    @(posedge clk); #1;
    total++; if (out_sel !== 2'd1) begin bad++; $display("FAIL wrap_prep_sel got=%0d exp=1", out_sel); end
    @(negedge clk);
    in_valid = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++; if (out_sel !== 2'(seq[c]) || out_data !== chv(seq[c]))
        begin bad++; $display("FAIL wrap_out[%0d] got=s%0d d%h exp=s%0d", c, out_sel, out_data, seq[c]); end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    // out register holds ch3's word from the wrap test
    out_ready = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'b0001;
    in_data[0 +: W] = 32'h5555_AAAA;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL stall_in_ready[%0d] got=%b exp=0000", c, in_ready); end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || out_data !== chv(3) || out_sel !== 2'd3)
        begin bad++; $display("FAIL stall_hold[%0d] got=v%b d%h s%0d exp=v1 d%h s3", c, out_valid, out_data, out_sel, chv(3)); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL unstall_in_ready got=%b exp=0001", in_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || out_data !== 32'h5555_AAAA || out_sel !== 2'd0)
      begin bad++; $display("FAIL unstall_load got=v%b d%h s%0d exp=v1 d5555aaaa s0", out_valid, out_data, out_sel); end
    set_default_data();
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    // move ptr to 2 so the reset has something to clear
    mode = 1'b1; in_valid = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 4'b1111;
    #1;
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL midrst_in_ready got=%b exp=0000", in_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 2'd0)
      begin bad++; $display("FAIL midrst_out got=v%b d%h s%0d exp=v0 d0 s0", out_valid, out_data, out_sel); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL midrst_ptr got=%b exp=0001", in_ready); end
    @(posedge clk); #1;
    total++; if (out_sel !== 2'd0 || out_valid !== 1'b1) begin bad++; $display("FAIL midrst_first got=s%0d v%b exp=s0 v1", out_sel, out_valid); end
  endtask

`ifdef YMUX_PIPE_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    for (int k = 0; k < 3; k++) s_data[k*W +: W] = chv(k);
    s_mode = 1'b0; s_sel = 2'd3; s_valid = 3'b111; s_ordy = 1'b1;
    #1;
    total++; if (s_ready !== 3'b000) begin bad++; $display("FAIL stats_bad_sel_ready got=%b exp=000", s_ready); end
    @(posedge clk); #1;
    total++; if (s_drop !== 1'b1) begin bad++; $display("FAIL stats_drop_sel got=%b exp=1", s_drop); end
    @(negedge clk);
    s_mode = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    total++; if (s_cnt !== 16'hFFFF) begin bad++; $display("FAIL stats_xfer_sat got=%h exp=ffff", s_cnt); end
  endtask
`endif

  initial begin
`ifdef YMUX_PIPE_STATS_EN
    s_data = '0; s_valid = '0; s_mode = 1'b0; s_sel = '0; s_ordy = 1'b0;
`endif
    test_reset();
    test_fixed();
    test_back_to_back();
    test_rr_wrap();
    test_stall();
    test_mid_reset();
`ifdef YMUX_PIPE_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
